// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store bridge between the core memory stage and a
// synchronous data RAM (1-cycle read latency, byte-lane write enables).
// Stores and misaligned requests complete in 1 cycle; loads take 2 cycles.
// req_ready drops while a load waits on RAM data, which stalls the core.
// Optional build macro MEM_BIG_ENDIAN_EN mirrors byte and halfword lanes.
// When it is not defined, lanes are little-endian.

module mem_access_unit #(
  parameter int RAM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  // core request side
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  // core response side
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        adel,
  output logic        ades,
  output logic [31:0] bad_vaddr,
  // data RAM side
  output logic        dce,
  output logic [31:0] daddr,
  output logic [3:0]  we,
  output logic [31:0] din,
  input  logic [31:0] dm
);

  // Operation encodings presented by the core.
  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LWAIT = 2'd1,
    LRESP = 2'd2
  } state_t;

  state_t      state_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        adel_q;
  logic        ades_q;
  logic [31:0] bad_vaddr_q;
  logic [2:0]  ld_op_q;
  logic [1:0]  ld_off_q;

  logic        accept;
  logic        is_store;
  logic        sz_byte;
  logic        sz_half;
  logic        sz_word;
  logic        misaligned;
  logic [3:0]  store_we;
  logic [31:0] store_din;
  logic [31:0] load_data_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Map a byte offset onto a physical RAM byte lane.
  function automatic logic [1:0] byte_lane(input logic [1:0] off);
`ifdef MEM_BIG_ENDIAN_EN
    return ~off;
`else
    return off;
`endif
  endfunction

  // Decide whether a halfword offset lives in the upper RAM half (bits 31:16).
  function automatic logic half_upper(input logic off1);
`ifdef MEM_BIG_ENDIAN_EN
    return ~off1;
`else
    return off1;
`endif
  endfunction

  // Stalled only while a load waits for RAM data; never ready during reset.
  assign req_ready = !rst && (state_q != LWAIT);
  assign accept    = req_valid && req_ready;

  // Decode the access size and direction, and check natural alignment.
  always_comb begin
    is_store   = 1'b0;
    sz_byte    = 1'b0;
    sz_half    = 1'b0;
    sz_word    = 1'b0;
    misaligned = 1'b0;
    unique case (req_op)
      OP_LB, OP_LBU: sz_byte = 1'b1;
      OP_LH, OP_LHU: sz_half = 1'b1;
      OP_LW:         sz_word = 1'b1;
      OP_SB: begin
        sz_byte  = 1'b1;
        is_store = 1'b1;
      end
      OP_SH: begin
        sz_half  = 1'b1;
        is_store = 1'b1;
      end
      OP_SW: begin
        sz_word  = 1'b1;
        is_store = 1'b1;
      end
      default: sz_word = 1'b1;
    endcase
    if (sz_half && req_addr[0]) begin
      misaligned = 1'b1;
    end
    if (sz_word && (req_addr[1:0] != 2'b00)) begin
      misaligned = 1'b1;
    end
  end

  // Build store lane enables and replicate store data across all lanes, so
  // the RAM picks up the right bytes whichever lanes are enabled.
  always_comb begin
    store_we  = 4'b0000;
    store_din = req_wdata;
    if (sz_byte) begin
      store_we  = 4'b0001 << byte_lane(req_addr[1:0]);
      store_din = {4{req_wdata[7:0]}};
    end else if (sz_half) begin
      store_we  = half_upper(req_addr[1]) ? 4'b1100 : 4'b0011;
      store_din = {2{req_wdata[15:0]}};
    end else begin
      store_we  = 4'b1111;
      store_din = req_wdata;
    end
  end

  // The RAM port is live only in the cycle an aligned request is accepted.
  assign dce   = accept && !misaligned;
  assign we    = (accept && !misaligned && is_store) ? store_we : 4'b0000;
  assign din   = store_din;
  assign daddr = {{(32 - RAM_AW){1'b0}}, req_addr[RAM_AW-1:2], 2'b00};

  // Select the addressed lane(s) from RAM data and extend to 32 bits.
  always_comb begin
    ld_byte     = dm[{byte_lane(ld_off_q), 3'b000} +: 8];
    ld_half     = half_upper(ld_off_q[1]) ? dm[31:16] : dm[15:0];
    load_data_d = dm;
    case (ld_op_q)
      OP_LB:   load_data_d = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_data_d = {24'h000000, ld_byte};
      OP_LH:   load_data_d = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_data_d = {16'h0000, ld_half};
      default: load_data_d = dm;
    endcase
  end

  // Control FSM with registered response, exception and fault-address outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      adel_q       <= 1'b0;
      ades_q       <= 1'b0;
      bad_vaddr_q  <= 32'h0000_0000;
      ld_op_q      <= OP_LB;
      ld_off_q     <= 2'b00;
    end else begin
      resp_valid_q <= 1'b0;
      adel_q       <= 1'b0;
      ades_q       <= 1'b0;
      case (state_q)
        IDLE, LRESP: begin
          if (accept) begin
            if (misaligned) begin
              // Faulting access: no RAM cycle, flag the exception next cycle.
              adel_q      <= !is_store;
              ades_q      <= is_store;
              bad_vaddr_q <= req_addr;
              state_q     <= IDLE;
            end else if (is_store) begin
              // Store retires as soon as the write is issued.
              resp_valid_q <= 1'b1;
              resp_rdata_q <= 32'h0000_0000;
              state_q      <= IDLE;
            end else begin
              // Load: remember how to extract the data when it returns.
              ld_op_q  <= req_op;
              ld_off_q <= req_addr[1:0];
              state_q  <= LWAIT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        LWAIT: begin
          resp_rdata_q <= load_data_d;
          resp_valid_q <= 1'b1;
          state_q      <= LRESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign adel       = adel_q;
  assign ades       = ades_q;
  assign bad_vaddr  = bad_vaddr_q;

  // A completed access and an address error are mutually exclusive.
  a_resp_exc_excl: assert property (@(posedge clk) disable iff (rst)
    !(resp_valid && (adel || ades)));

  // Byte writes are only ever issued together with a RAM enable.
  a_we_needs_dce: assert property (@(posedge clk) (we != 4'b0000) |-> dce);

  // The core is never told the unit is ready while a load is in flight.
  a_stall_in_lwait: assert property (@(posedge clk) disable iff (rst)
    (state_q == LWAIT) |-> !req_ready);

endmodule
